// File: rtl/uart_tx_feeder.sv
// Byte FIFO and frame launcher feeding the UART transmit serializer.
// Paces one start pulse per 11 bit-clocks so frames never overrun.
module uart_tx_feeder #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_clk_tx,
  input  logic              i_reset,
  input  logic              i_wr_valid,
  input  logic [7:0]        i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_flush,
  output logic              o_start,
  output logic [7:0]        o_data,
  output logic              o_busy,
  output logic [ADDR_W:0]   o_count
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    HOLD
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE =
    (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE =
    ADDR_W'(1);

  state_t            state;
  state_t            state_n;
  logic [3:0]        hold_cnt;
  logic [3:0]        hold_n;
  logic              start_n;
  logic              pop;
  logic              push;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic [7:0]        mem [DEPTH];

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign o_wr_ready = ~full;
  assign o_count    = count;
  assign o_busy     = (state != IDLE) | ~empty;

  // A pop on this edge frees a slot, so a full FIFO can still take a write.
  assign push = i_wr_valid & (~full | pop) & ~i_flush;

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    start_n = 1'b0;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !i_flush) begin
          pop     = 1'b1;
          start_n = 1'b1;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
        hold_n  = 4'd9;
        state_n = HOLD;
      end
      HOLD: begin
        if (hold_cnt == 4'd0) begin
          if (!empty && !i_flush) begin
            pop     = 1'b1;
            start_n = 1'b1;
            state_n = LAUNCH;
          end else begin
            state_n = IDLE;
          end
        end else begin
          hold_n = hold_cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_tx or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      hold_cnt <= 4'd0;
      o_start  <= 1'b0;
      o_data   <= 8'h00;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      o_start  <= start_n;
      if (pop) o_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge i_clk_tx or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk_tx) begin
    if (push) mem[wr_ptr] <= i_wr_data;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: cycle table plus
// multi-cycle sequences for back-to-back, full, flush, reset.
module tb_uart_tx_feeder;

  logic       clk;
  logic       i_reset;
  logic       i_wr_valid;
  logic [7:0] i_wr_data;
  logic       o_wr_ready;
  logic       i_flush;
  logic       o_start;
  logic [7:0] o_data;
  logic       o_busy;
  logic [3:0] o_count;

  uart_tx_feeder #(.DEPTH(8), .ADDR_W(3)) dut (
    .i_clk_tx  (clk),
    .i_reset   (i_reset),
    .i_wr_valid(i_wr_valid),
    .i_wr_data (i_wr_data),
    .o_wr_ready(o_wr_ready),
    .i_flush   (i_flush),
    .o_start   (o_start),
    .o_data    (o_data),
    .o_busy    (o_busy),
    .o_count   (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       es;
    logic [7:0] ed;
    logic       eb;
    logic [3:0] ec;
    logic       er;
  } vec_t;

  vec_t tbl[15];

  int n_tests = 0;
  int n_fail  = 0;

  logic       sv[128];
  logic [7:0] sd[128];
  logic       sf[128];
  logic [3:0] cnt_a[128];
  logic       rdy_a[128];
  logic       busy_a[128];
  logic [7:0] dat_a[128];
  int         starts[$];
  logic [7:0] sdat[$];
  logic [3:0] maxc;
  logic [7:0] exp_d[16];
  int         exp_n;

  task automatic check(input string nm, input int c,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d got %0h want %0h",
               nm, c, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 128; i++) begin
      sv[i] = 1'b0;
      sd[i] = 8'h00;
      sf[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    starts.delete();
    sdat.delete();
    maxc = 4'd0;
    for (int c = 0; c < n; c++) begin
      i_wr_valid = sv[c];
      i_wr_data  = sd[c];
      i_flush    = sf[c];
      @(negedge clk);
      cnt_a[c]  = o_count;
      rdy_a[c]  = o_wr_ready;
      busy_a[c] = o_busy;
      dat_a[c]  = o_data;
      if (o_start) begin
        starts.push_back(c);
        sdat.push_back(o_data);
      end
      if (o_count > maxc) maxc = o_count;
      @(posedge clk); #1;
    end
    i_wr_valid = 1'b0;
    i_flush    = 1'b0;
  endtask

  task automatic check_frames(input string nm, input int nrun);
    int k;
    check({nm, "_nstart"}, 0, starts.size(), exp_n);
    for (int i = 0; i < exp_n; i++) begin
      if (i < starts.size()) begin
        k = starts[i];
        check({nm, "_start_cyc"}, i, k, 2 + 11 * i);
        check({nm, "_data"}, k, sdat[i], exp_d[i]);
        if (k + 10 < nrun)
          check({nm, "_hold"}, k + 10, dat_a[k + 10], exp_d[i]);
      end
    end
  endtask

  task automatic check_rst(input string nm);
    check({nm, "_start"}, 0, o_start, 1'b0);
    check({nm, "_data"},  0, o_data,  8'h00);
    check({nm, "_busy"},  0, o_busy,  1'b0);
    check({nm, "_count"}, 0, o_count, 4'd0);
    check({nm, "_ready"}, 0, o_wr_ready, 1'b1);
  endtask

  initial begin
    i_reset    = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_data  = 8'h00;
    i_flush    = 1'b0;

    for (int i = 0; i < 15; i++) begin
      tbl[i].v  = 1'b0;
      tbl[i].d  = 8'h00;
      tbl[i].es = (i == 2);
      tbl[i].ed = (i >= 2) ? 8'hA5 : 8'h00;
      tbl[i].eb = (i >= 1) && (i <= 12);
      tbl[i].ec = (i == 1) ? 4'd1 : 4'd0;
      tbl[i].er = 1'b1;
    end
    tbl[0].v = 1'b1;
    tbl[0].d = 8'hA5;

    // reset values
    @(posedge clk); #1;
    check_rst("rst");
    i_reset = 1'b1;
    @(posedge clk); #1;

    // single byte, cycle-by-cycle table
    for (int i = 0; i < 15; i++) begin
      i_wr_valid = tbl[i].v;
      i_wr_data  = tbl[i].d;
      @(negedge clk);
      check("t_start", i, o_start, tbl[i].es);
      check("t_data",  i, o_data,  tbl[i].ed);
      check("t_busy",  i, o_busy,  tbl[i].eb);
      check("t_count", i, o_count, tbl[i].ec);
      check("t_ready", i, o_wr_ready, tbl[i].er);
      @(posedge clk); #1;
    end

    // back-to-back frames
    do_reset();
    clear_stim();
    for (int i = 0; i < 3; i++) begin
      sv[i] = 1'b1;
      sd[i] = 8'(i + 1);
    end
    run(40);
    exp_n = 3;
    exp_d[0] = 8'h01;
    exp_d[1] = 8'h02;
    exp_d[2] = 8'h03;
    check_frames("b2b", 40);
    check("b2b_peak", 0, maxc, 4'd2);
    check("b2b_idle", 39, busy_a[39], 1'b0);

    // fill to full, drops, then push at full on the pop edge
    do_reset();
    clear_stim();
    for (int i = 0; i < 12; i++) begin
      sv[i] = 1'b1;
      sd[i] = 8'(i);
    end
    sv[12] = 1'b1;
    sd[12] = 8'hEE;
    run(115);
    check("full_cnt9",  9,  cnt_a[9],  4'd8);
    check("full_rdy9",  9,  rdy_a[9],  1'b0);
    check("full_cnt12", 12, cnt_a[12], 4'd8);
    check("full_cnt13", 13, cnt_a[13], 4'd8);
    check("full_rdy13", 13, rdy_a[13], 1'b0);
    exp_n = 10;
    for (int i = 0; i < 9; i++) exp_d[i] = 8'(i);
    exp_d[9] = 8'hEE;
    check_frames("full", 115);
    check("full_end", 114, busy_a[114], 1'b0);

    // flush mid-frame
    do_reset();
    clear_stim();
    sv[0] = 1'b1; sd[0] = 8'h11;
    sv[1] = 1'b1; sd[1] = 8'h22;
    sv[2] = 1'b1; sd[2] = 8'h33;
    sf[8] = 1'b1;
    run(30);
    check("fl_cnt8",  8,  cnt_a[8],  4'd2);
    check("fl_cnt9",  9,  cnt_a[9],  4'd0);
    check("fl_busy12", 12, busy_a[12], 1'b1);
    check("fl_busy13", 13, busy_a[13], 1'b0);
    check("fl_data29", 29, dat_a[29], 8'h11);
    exp_n = 1;
    exp_d[0] = 8'h11;
    check_frames("fl", 30);

    // asynchronous reset mid-frame
    do_reset();
    clear_stim();
    sv[0] = 1'b1; sd[0] = 8'hAB;
    sv[1] = 1'b1; sd[1] = 8'hCD;
    sv[2] = 1'b1; sd[2] = 8'hEF;
    run(6);
    check("mr_pre_cnt", 5, cnt_a[5], 4'd2);
    #2;
    i_reset = 1'b0;
    #1;
    check_rst("mr");
    @(posedge clk); #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    clear_stim();
    sv[0] = 1'b1; sd[0] = 8'h5A;
    run(16);
    exp_n = 1;
    exp_d[0] = 8'h5A;
    check_frames("mr", 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
